// File: rtl/dqn_pkg.sv
// Constants and state encoding shared by the state encoder, the index
// decoder and the control unit of the DQN datapath.
package dqn_pkg;

  localparam int DQN_W        = 16;          // element width, signed Q6.10
  localparam int DQN_FRAC     = 10;          // fractional bits
  localparam logic [15:0] DQN_ONE = 16'h0400; // 1.0 in Q6.10
  localparam int DQN_N_STATES = 9;           // number of states/actions

  // Decoder FSM: wait for start, walk the vector, pulse done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } dqn_state_e;

endpackage

// File: rtl/matrix_to_index_module.sv
// Serial arg-max decoder: captures an N-element Q6.10 vector on start,
// scans one element per clock and reports the 1-based index of the signed
// maximum, the maximum itself and whether the vector was an exact one-hot
// 1.0 encoding.
//
// Handshake: start is a request sampled only in IDLE; the accepting edge
// captures in_vec and raises busy. done is a one-cycle pulse that marks
// idx/max_val/onehot_ok as valid; those hold until the next done. There is
// no backpressure and a start outside IDLE is dropped, not queued.
module matrix_to_index_module
  import dqn_pkg::*;
#(
  parameter int N = DQN_N_STATES,
  parameter int W = DQN_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N*W-1:0] in_vec,
  output logic           busy,
  output logic           done,
  output logic [3:0]     idx,
  output logic [W-1:0]   max_val,
  output logic           onehot_ok
);

  localparam logic [W-1:0] ONE_W  = W'(DQN_ONE);
  localparam logic [3:0]   LAST_P = 4'(N - 1);

  dqn_state_e      state_q, state_d;
  logic [N*W-1:0]  vec_q, vec_d;
  logic [W-1:0]    best_q, best_d;
  logic [3:0]      best_idx_q, best_idx_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [1:0]      ones_cnt_q, ones_cnt_d;
  logic            bad_q, bad_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      idx_q, idx_d;
  logic [W-1:0]    max_val_q, max_val_d;
  logic            onehot_ok_q, onehot_ok_d;

  // Scan datapath intermediates
  logic [W-1:0]    elem;
  logic [W-1:0]    elem0;
  logic            take;
  logic [W-1:0]    best_next;
  logic [3:0]      best_idx_next;
  logic [1:0]      ones_next;
  logic            bad_next;

  // Select the element under the scan pointer and fold it into the running
  // maximum and one-hot tracking.
  always_comb begin
    elem = '0;
    for (int k = 0; k < N; k++) begin
      if (ptr_q == 4'(k)) elem = vec_q[k*W +: W];
    end
    elem0 = in_vec[W-1:0];

    // Strict compare: on a tie the earlier (lower) index is kept.
    take          = $signed(elem) > $signed(best_q);
    best_next     = take ? elem : best_q;
    best_idx_next = take ? (ptr_q + 4'd1) : best_idx_q;

    // Count exact 1.0 elements, saturating at 2 ("more than one").
    ones_next = ones_cnt_q;
    if ((elem == ONE_W) && (ones_cnt_q != 2'd2)) ones_next = ones_cnt_q + 2'd1;
    bad_next = bad_q | ((elem != ONE_W) && (elem != '0));
  end

  // Next-state and register-update logic for the decoder FSM.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    ptr_d       = ptr_q;
    ones_cnt_d  = ones_cnt_q;
    bad_d       = bad_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    idx_d       = idx_q;
    max_val_d   = max_val_q;
    onehot_ok_d = onehot_ok_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Element 0 seeds the maximum; the scan continues from element 1.
          vec_d      = in_vec;
          best_d     = elem0;
          best_idx_d = 4'd1;
          ptr_d      = 4'd1;
          ones_cnt_d = (elem0 == ONE_W) ? 2'd1 : 2'd0;
          bad_d      = (elem0 != ONE_W) && (elem0 != '0);
          busy_d     = 1'b1;
          state_d    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        best_d     = best_next;
        best_idx_d = best_idx_next;
        ones_cnt_d = ones_next;
        bad_d      = bad_next;
        ptr_d      = ptr_q + 4'd1;
        if (ptr_q == LAST_P) begin
          // Last element folded in this cycle: publish the result.
          idx_d       = best_idx_next;
          max_val_d   = best_next;
          onehot_ok_d = (ones_next == 2'd1) && !bad_next;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          ptr_d       = 4'd0;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any decode in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      ptr_q       <= '0;
      ones_cnt_q  <= '0;
      bad_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      max_val_q   <= '0;
      onehot_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      ptr_q       <= ptr_d;
      ones_cnt_q  <= ones_cnt_d;
      bad_q       <= bad_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      max_val_q   <= max_val_d;
      onehot_ok_q <= onehot_ok_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign idx       = idx_q;
  assign max_val   = max_val_q;
  assign onehot_ok = onehot_ok_q;

endmodule

// File: tb/tb_matrix_to_index_module.sv
// Directed bench for the serial arg-max / one-hot decoder.
module tb_matrix_to_index_module;
  import dqn_pkg::*;

  localparam int N = 9;
  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N*W-1:0] in_vec;
  logic           busy;
  logic           done;
  logic [3:0]     idx;
  logic [W-1:0]   max_val;
  logic           onehot_ok;

  int checks;
  int errors;

  matrix_to_index_module #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_vec    (in_vec),
    .busy      (busy),
    .done      (done),
    .idx       (idx),
    .max_val   (max_val),
    .onehot_ok (onehot_ok)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Encoder model: state k (1..N) -> element k-1 = 1.0, others 0; k=0 -> all zero.
  function automatic logic [N*W-1:0] enc(input int k);
    logic [N*W-1:0] v;
    v = '0;
    if (k >= 1 && k <= N) v[(k-1)*W +: W] = DQN_ONE;
    return v;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full decode from IDLE: accept, measure latency, check result, check done falls.
  task automatic run_decode(input logic [N*W-1:0] v, input logic [3:0] e_idx,
                            input logic [W-1:0] e_max, input logic e_ok,
                            input string name);
    int cyc;
    in_vec = v;
    start  = 1'b1;
    tick();                      // T0
    start  = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got %b want 1", name, busy);
    end
    cyc = 0;
    while (cyc < 20 && done !== 1'b1) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL %s latency got %0d want 8", name, cyc);
    end
    checks++;
    if (idx !== e_idx) begin
      errors++;
      $display("FAIL %s idx got %0d want %0d", name, idx, e_idx);
    end
    checks++;
    if (max_val !== e_max) begin
      errors++;
      $display("FAIL %s max_val got %h want %h", name, max_val, e_max);
    end
    checks++;
    if (onehot_ok !== e_ok) begin
      errors++;
      $display("FAIL %s onehot_ok got %b want %b", name, onehot_ok, e_ok);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done got %b want 0", name, busy);
    end
    tick();                      // T9: done falls, back in IDLE
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_fall got %b want 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    in_vec = '0;
    tick();
    tick();
    checks++;
    if ({busy, done, idx, max_val, onehot_ok} !== '0) begin
      errors++;
      $display("FAIL reset outputs got busy=%b done=%b idx=%0d max=%h ok=%b want all 0",
               busy, done, idx, max_val, onehot_ok);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset idle_after_release got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_state5();
    run_decode(enc(5), 4'd5, 16'h0400, 1'b1, "state5");
  endtask

  // -3.0, -1.5, then -2.0 everywhere else: signed max is element 1.
  task automatic test_signed();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = 16'hF800;
    v[0*W +: W] = 16'hF400;
    v[1*W +: W] = 16'hFA00;
    run_decode(v, 4'd2, 16'hFA00, 1'b0, "signed");
  endtask

  // Two equal maxima at elements 3 and 7: index 4 must win.
  task automatic test_tie();
    logic [N*W-1:0] v;
    v = '0;
    v[3*W +: W] = 16'h0C00;
    v[7*W +: W] = 16'h0C00;
    run_decode(v, 4'd4, 16'h0C00, 1'b0, "tie");
  endtask

  task automatic test_roundtrip();
    for (int k = 1; k <= N; k++) begin
      run_decode(enc(k), 4'(k), 16'h0400, 1'b1, $sformatf("roundtrip%0d", k));
    end
    run_decode('0, 4'd1, 16'h0000, 1'b0, "all_zero");
  endtask

  // Held start: accepts at T0, T10, T20 give done at cycles 8, 18, 28.
  task automatic test_back_to_back();
    int n_done;
    int pos [3];
    in_vec = enc(2);
    start  = 1'b1;
    tick();                      // T0
    n_done = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (done === 1'b1) begin
        if (n_done < 3) pos[n_done] = c;
        n_done++;
      end
    end
    start = 1'b0;
    checks++;
    if (n_done !== 3) begin
      errors++;
      $display("FAIL b2b done_count got %0d want 3", n_done);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pos[i] !== 8 + 10*i) begin
          errors++;
          $display("FAIL b2b done_cycle%0d got %0d want %0d", i, pos[i], 8 + 10*i);
        end
      end
    end
    checks++;
    if (idx !== 4'd2 || onehot_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b result got idx=%0d ok=%b want 2 1", idx, onehot_ok);
    end
    // Drain any decode still in flight so the next test starts from IDLE.
    for (int c = 0; c < 12; c++) tick();
  endtask

  // Extra start during SCAN and in_vec change at T2 must not disturb the decode.
  task automatic test_start_during_scan();
    int n_done;
    logic [3:0] got_idx;
    logic       got_ok;
    in_vec = enc(3);
    start  = 1'b1;
    tick();                      // T0
    start  = 1'b0;
    n_done = 0;
    got_idx = '0;
    got_ok  = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) start = 1'b1;
      if (c == 2) begin
        start  = 1'b0;
        in_vec = enc(9);
      end
      if (c == 3) begin
        checks++;
        if (idx !== 4'd2) begin
          errors++;
          $display("FAIL scan idx_held got %0d want 2", idx);
        end
      end
      if (done === 1'b1) begin
        n_done++;
        got_idx = idx;
        got_ok  = onehot_ok;
      end
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL scan done_count got %0d want 1", n_done);
    end
    checks++;
    if (got_idx !== 4'd3 || got_ok !== 1'b1) begin
      errors++;
      $display("FAIL scan captured got idx=%0d ok=%b want 3 1", got_idx, got_ok);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL scan start_not_queued busy got %b want 0", busy);
    end
    run_decode(enc(8), 4'd8, 16'h0400, 1'b1, "after_scan");
  endtask

  // Reset at T4 aborts the decode with no done; a fresh decode then works.
  task automatic test_reset_mid();
    int n_done;
    in_vec = enc(7);
    start  = 1'b1;
    tick();                      // T0
    start  = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || idx !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid async got busy=%b idx=%0d done=%b want 0 0 0", busy, idx, done);
    end
    tick();
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL rstmid no_done got %0d want 0", n_done);
    end
    run_decode(enc(6), 4'd6, 16'h0400, 1'b1, "after_rst");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    in_vec = '0;
    test_reset();
    test_state5();
    test_signed();
    test_tie();
    test_roundtrip();
    test_back_to_back();
    // Leave idx at 2 before the scan test checks that it is held.
    run_decode(enc(2), 4'd2, 16'h0400, 1'b1, "preload");
    test_start_during_scan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
